// File: rtl/gray_seq_monitor.sv
// Gray-code count stream monitor: converts samples to binary, checks for legal
// up-count steps, and tracks lock, step errors, wraps and a saturating error count.
module gray_seq_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_N    = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr_err,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 locked,
  output logic                 step_err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GCW = 4;
  localparam logic [GCW-1:0]       LOCK_TGT = GCW'(LOCK_N);
  localparam logic [WIDTH-1:0]     BIN_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d, nb, bin_d;
  logic [GCW-1:0]       gc_q, gc_d;
  logic [ERR_CNT_W-1:0] err_d;
  logic                 ov_d, serr_d, wrap_d, locked_d;
  logic                 is_rep, is_good;

  // Binary bit i is the XOR of Gray bits i..WIDTH-1
  always_comb begin
    nb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nb[i] = ^(gray_in >> i);
    end
  end

  assign is_rep  = (nb == prev_q);
  assign is_good = (nb == prev_q + WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    gc_d     = gc_q;
    bin_d    = bin_out;
    ov_d     = 1'b0;
    serr_d   = 1'b0;
    wrap_d   = 1'b0;
    if (in_valid) begin
      ov_d   = 1'b1;
      prev_d = nb;
      bin_d  = nb;
      case (state_q)
        SEARCH: begin
          state_d = LOCKING;
          gc_d    = '0;
        end
        LOCKING: begin
          wrap_d = is_good && (prev_q == BIN_MAX);
          if (is_good) begin
            gc_d = gc_q + GCW'(1);
            if (gc_q + GCW'(1) == LOCK_TGT) state_d = LOCKED;
          end else if (!is_rep) begin
            gc_d = '0;
          end
        end
        LOCKED: begin
          wrap_d = is_good && (prev_q == BIN_MAX);
          if (!is_good && !is_rep) begin
            serr_d  = 1'b1;
            gc_d    = '0;
            state_d = LOCKING;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);

    // Clear wins over hold, but an error in the same cycle still counts once
    err_d = err_count;
    if (clr_err) begin
      err_d = serr_d ? ERR_CNT_W'(1) : '0;
    end else if (serr_d && (err_count != ERR_MAX)) begin
      err_d = err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      gc_q      <= '0;
      bin_out   <= '0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      gc_q      <= gc_d;
      bin_out   <= bin_d;
      out_valid <= ov_d;
      locked    <= locked_d;
      step_err  <= serr_d;
      wrap      <= wrap_d;
      err_count <= err_d;
    end
  end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Scoreboard bench for gray_seq_monitor: a default instance and a 2-bit error
// counter instance driven by the same stimulus.
module tb_gray_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic       clr_err;

  logic       out_valid, locked, step_err, wrap;
  logic [3:0] bin_out;
  logic [7:0] err_count;
  logic       s_out_valid, s_locked, s_step_err, s_wrap;
  logic [3:0] s_bin_out;
  logic [1:0] s_err_count;

  always #5 clk = ~clk;

  gray_seq_monitor #(.WIDTH(4), .LOCK_N(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
    .out_valid(out_valid), .bin_out(bin_out), .locked(locked), .step_err(step_err),
    .wrap(wrap), .err_count(err_count)
  );

  gray_seq_monitor #(.WIDTH(4), .LOCK_N(3), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
    .out_valid(s_out_valid), .bin_out(s_bin_out), .locked(s_locked), .step_err(s_step_err),
    .wrap(s_wrap), .err_count(s_err_count)
  );

  typedef struct {
    logic       ov;
    logic [3:0] bin;
    logic       lck;
    logic       serr;
    logic       wrp;
    logic [7:0] err8;
    logic [1:0] err2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   wrap_cnt = 0;

  // Reference model state
  int         m_state;
  logic [3:0] m_prev, m_bin;
  int         m_gc;
  logic [7:0] m_err8;
  logic [1:0] m_err2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = '0; m_bin = '0; m_gc = 0; m_err8 = '0; m_err2 = '0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] g, input logic c, output exp_t e);
    logic [3:0] b;
    logic good, rep;
    e.ov = 1'b0; e.serr = 1'b0; e.wrp = 1'b0;
    if (v) begin
      b = g2b(g);
      e.ov = 1'b1;
      good = (b == 4'(m_prev + 4'd1));
      rep  = (b == m_prev);
      if (m_state == 0) begin
        m_state = 1; m_gc = 0;
      end else begin
        if (good && m_prev == 4'd15) e.wrp = 1'b1;
        if (m_state == 1) begin
          if (good) begin
            m_gc++;
            if (m_gc == 3) m_state = 2;
          end else if (!rep) m_gc = 0;
        end else if (!good && !rep) begin
          e.serr = 1'b1; m_gc = 0; m_state = 1;
        end
      end
      m_prev = b; m_bin = b;
    end
    if (c) begin
      m_err8 = e.serr ? 8'd1 : 8'd0;
      m_err2 = e.serr ? 2'd1 : 2'd0;
    end else if (e.serr) begin
      if (m_err8 != 8'hFF) m_err8++;
      if (m_err2 != 2'd3) m_err2++;
    end
    e.bin = m_bin; e.lck = (m_state == 2); e.err8 = m_err8; e.err2 = m_err2;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (wrap) wrap_cnt++;
    check("out_valid", 32'(out_valid), 32'(e.ov));
    check("bin_out",   32'(bin_out),   32'(e.bin));
    check("locked",    32'(locked),    32'(e.lck));
    check("step_err",  32'(step_err),  32'(e.serr));
    check("wrap",      32'(wrap),      32'(e.wrp));
    check("err_count", 32'(err_count), 32'(e.err8));
    check("s_err_count", 32'(s_err_count), 32'(e.err2));
    check("s_locked",  32'(s_locked),  32'(e.lck));
  endtask

  task automatic drive(input logic v, input logic [3:0] g, input logic c);
    exp_t e;
    @(negedge clk);
    in_valid = v; gray_in = g; clr_err = c;
    model_step(v, g, c, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic feed_bin(input logic [3:0] b);
    drive(1'b1, b2g(b), 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ov"},   32'(out_valid), 32'd0);
    check({tag, "_bin"},  32'(bin_out),   32'd0);
    check({tag, "_lck"},  32'(locked),    32'd0);
    check({tag, "_serr"}, 32'(step_err),  32'd0);
    check({tag, "_wrap"}, 32'(wrap),      32'd0);
    check({tag, "_err"},  32'(err_count), 32'd0);
    check({tag, "_serr2"}, 32'(s_err_count), 32'd0);
  endtask

  // Bad jump then three good steps to relock; returns the new current value
  task automatic error_relock(inout logic [3:0] cur);
    cur = cur + 4'd3;
    feed_bin(cur);
    for (int k = 0; k < 3; k++) begin
      cur = cur + 4'd1;
      feed_bin(cur);
    end
  endtask

  initial begin
    logic [3:0] cur;
    logic [1:0] sat_exp [3];
    sat_exp[0] = 2'd2; sat_exp[1] = 2'd3; sat_exp[2] = 2'd3;
    rst = 1'b0; in_valid = 1'b0; gray_in = '0; clr_err = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Lock-in: gray 0,0,1,3,2,6
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    check("lockin_locked", 32'(locked), 32'd1);
    drive(1'b1, 4'h6, 1'b0);
    check("lockin_bin4", 32'(bin_out), 32'd4);

    // Wrap: climb to 13, then gray 9,8,0
    for (int b = 5; b <= 13; b++) feed_bin(4'(b));
    wrap_cnt = 0;
    drive(1'b1, 4'h9, 1'b0);
    drive(1'b1, 4'h8, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    check("wrap_once", 32'(wrap_cnt), 32'd1);
    check("wrap_locked", 32'(locked), 32'd1);

    // Step error at bin 5 -> bin 8, then relock on 9,10,11
    for (int b = 1; b <= 5; b++) feed_bin(4'(b));
    drive(1'b1, 4'hC, 1'b0);
    check("serr_pulse", 32'(step_err), 32'd1);
    check("serr_cnt", 32'(err_count), 32'd1);
    check("serr_unlock", 32'(locked), 32'd0);
    drive(1'b1, 4'hD, 1'b0);
    drive(1'b1, 4'hF, 1'b0);
    drive(1'b1, 4'hE, 1'b0);
    check("relock", 32'(locked), 32'd1);

    // Saturation on the 2-bit counter
    cur = 4'd11;
    for (int n = 0; n < 3; n++) begin
      cur = cur + 4'd3;
      feed_bin(cur);
      check("sat_cnt", 32'(s_err_count), 32'(sat_exp[n]));
      for (int k = 0; k < 3; k++) begin
        cur = cur + 4'd1;
        feed_bin(cur);
      end
    end
    cur = cur + 4'd3;
    drive(1'b1, b2g(cur), 1'b1);
    check("clr_inc", 32'(s_err_count), 32'd1);
    check("clr_inc8", 32'(err_count), 32'd1);
    drive(1'b0, 4'(($urandom_range(0, 15))), 1'b1);
    check("clr_only", 32'(s_err_count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cur = cur + 4'd1;
      feed_bin(cur);
    end

    // Reach err_count=2 while locked, then async reset between edges
    error_relock(cur);
    error_relock(cur);
    check("pre_rst_err", 32'(err_count), 32'd2);
    check("pre_rst_lck", 32'(locked), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 4'h5, 1'b0);
    check("post_rst_bin", 32'(bin_out), 32'd6);
    check("post_rst_lck", 32'(locked), 32'd0);
    check("post_rst_serr", 32'(step_err), 32'd0);

    // Valid gaps: lock, walk to 1, feed gray 3, idle 4, feed gray 2
    for (int b = 7; b <= 15; b++) feed_bin(4'(b));
    feed_bin(4'd0);
    feed_bin(4'd1);
    drive(1'b1, 4'h3, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'(($urandom_range(0, 15))), 1'b0);
    check("gap_hold", 32'(bin_out), 32'd2);
    drive(1'b1, 4'h2, 1'b0);
    check("gap_after", 32'(bin_out), 32'd3);
    check("gap_lck", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
